// File: rtl/count_run_arbiter.sv
// count_run_arbiter: round-robin time-sharing of one up/down loadable counter between two requesters,
// loading, stepping and checking each count run and reporting completion.
module count_run_arbiter #(
    parameter int LOAD_CYCLES = 2,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_start,
    input  logic [W-1:0] req0_stop,
    input  logic         req0_dir,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_start,
    input  logic [W-1:0] req1_stop,
    input  logic         req1_dir,
    output logic         cnt_load_n,
    output logic         cnt_dir,
    output logic [W-1:0] cnt_d,
    input  logic [W-1:0] cnt_q,
    output logic         busy,
    output logic         done_valid,
    output logic         done_id,
    output logic         done_err
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam int LW = LOAD_CYCLES > 1 ? $clog2(LOAD_CYCLES) : 1;

    state_t state_q, state_d;
    logic rr_q, rr_d, id_q, id_d, err_q, err_d, dir_q, dir_d;
    logic [W-1:0] start_q, start_d, stop_q, stop_d, park_q, park_d;
    logic [W-1:0] exp_q, exp_d, n_q, n_d, k_q, k_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic gnt, hs, legal, g_dir;
    logic [W-1:0] g_start, g_stop;

    always_comb begin
        gnt = (req0_valid && req1_valid) ? rr_q : req1_valid;
        hs = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = hs && !gnt;
        req1_ready = hs && gnt;
        g_start = gnt ? req1_start : req0_start;
        g_stop = gnt ? req1_stop : req0_stop;
        g_dir = gnt ? req1_dir : req0_dir;
        legal = g_dir ? (g_stop >= g_start) : (g_stop <= g_start);
    end

    always_comb begin
        state_d = state_q;
        rr_d = rr_q;
        id_d = id_q;
        err_d = err_q;
        dir_d = dir_q;
        start_d = start_q;
        stop_d = stop_q;
        park_d = park_q;
        exp_d = exp_q;
        n_d = n_q;
        k_d = k_q;
        lcnt_d = lcnt_q;
        case (state_q)
            IDLE: if (hs) begin
                rr_d = ~gnt;
                id_d = gnt;
                err_d = !legal;
                state_d = legal ? LOAD : DONE;
                if (legal) begin
                    start_d = g_start;
                    stop_d = g_stop;
                    dir_d = g_dir;
                    lcnt_d = '0;
                end
            end
            LOAD: begin
                n_d = dir_q ? stop_q - start_q : start_q - stop_q;
                exp_d = start_q;
                k_d = '0;
                lcnt_d = lcnt_q + 1'b1;
                if (lcnt_q == LW'(LOAD_CYCLES - 1)) state_d = RUN;
            end
            RUN: if (cnt_q != exp_q) begin
                err_d = 1'b1;
                park_d = cnt_q;
                state_d = DONE;
            end else if (k_q == n_q) begin
                err_d = 1'b0;
                park_d = stop_q;
                state_d = DONE;
            end else begin
                exp_d = dir_q ? exp_q + 1'b1 : exp_q - 1'b1;
                k_d = k_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // counter controls are decoded from registered state only, so the final RUN cycle parks on stop unconditionally
    always_comb begin
        busy = state_q != IDLE;
        done_valid = state_q == DONE;
        done_id = done_valid && id_q;
        done_err = done_valid && err_q;
        cnt_load_n = (state_q == RUN) && (k_q != n_q);
        cnt_dir = dir_q;
        cnt_d = (state_q == LOAD) ? start_q : ((state_q == RUN) && (k_q == n_q)) ? stop_q : park_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q <= 1'b0;
            id_q <= 1'b0;
            err_q <= 1'b0;
            dir_q <= 1'b1;
            start_q <= '0;
            stop_q <= '0;
            park_q <= '0;
            exp_q <= '0;
            n_q <= '0;
            k_q <= '0;
            lcnt_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            id_q <= id_d;
            err_q <= err_d;
            dir_q <= dir_d;
            start_q <= start_d;
            stop_q <= stop_d;
            park_q <= park_d;
            exp_q <= exp_d;
            n_q <= n_d;
            k_q <= k_d;
            lcnt_q <= lcnt_d;
        end
    end
endmodule

// File: tb/tb_count_run_arbiter.sv
// tb_count_run_arbiter: transaction-level model predicts the per-cycle output transcript of every run;
// a single compare process checks the DUT against it each cycle, plus literal latency/park/grant checks.
module tb_count_run_arbiter;
    localparam int LC = 2;

    logic clk = 0, rst = 1;
    logic req0_valid = 0, req0_dir = 0, req1_valid = 0, req1_dir = 0;
    logic [3:0] req0_start = 0, req0_stop = 0, req1_start = 0, req1_stop = 0;
    logic req0_ready, req1_ready, cnt_load_n, cnt_dir, busy, done_valid, done_id, done_err;
    logic [3:0] cnt_d, cnt_q;

    count_run_arbiter #(.LOAD_CYCLES(LC), .W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_start(req0_start),
        .req0_stop(req0_stop), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_start(req1_start),
        .req1_stop(req1_stop), .req1_dir(req1_dir),
        .cnt_load_n(cnt_load_n), .cnt_dir(cnt_dir), .cnt_d(cnt_d), .cnt_q(cnt_q),
        .busy(busy), .done_valid(done_valid), .done_id(done_id), .done_err(done_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // external counter, with an optional read fault that shows 6 while it holds 5
    logic [3:0] cq = 0;
    logic inj = 0;
    always @(posedge clk) cq <= !cnt_load_n ? cnt_d : (cnt_dir ? cq + 4'd1 : cq - 4'd1);
    assign cnt_q = (inj && cq == 4'd5) ? 4'd6 : cq;

    typedef struct {
        bit load_n; bit dir; bit dir_care; logic [3:0] d; bit d_care; bit dv; bit id; bit err;
    } exp_t;
    exp_t q[$];
    logic [3:0] m_park = 0, m_tail = 0;
    bit m_rr = 0, cmp_en = 0;
    int checks = 0, failures = 0;
    int hs_cyc = 0, done_cyc = -1;
    bit done_id_l = 0, done_err_l = 0;

    function automatic void chk(string nm, int a, int b);
        checks++;
        if (a != b) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at cyc %0d", nm, a, b, cyc);
        end
    endfunction

    function automatic void push(bit ln, bit dr, bit dc, logic [3:0] d, bit ddc, bit dv, bit id, bit err);
        exp_t e;
        e.load_n = ln; e.dir = dr; e.dir_care = dc; e.d = d; e.d_care = ddc;
        e.dv = dv; e.id = id; e.err = err;
        q.push_back(e);
    endfunction

    // expected cycles after a handshake: LC load cycles, RUN k=0..N, then one DONE cycle
    function automatic void push_run(bit id, logic [3:0] s, logic [3:0] e, bit dir, int abort_k, logic [3:0] av);
        int n;
        if (dir ? (e < s) : (e > s)) begin
            push(0, 0, 0, m_tail, 1, 1, id, 1);
            return;
        end
        n = dir ? int'(e) - int'(s) : int'(s) - int'(e);
        for (int i = 0; i < LC; i++) push(0, dir, 1, s, 1, 0, 0, 0);
        for (int k = 0; k <= n; k++) begin
            push(k != n, dir, k != n, e, k == n, 0, 0, 0);
            if (k == abort_k) begin
                push(0, 0, 0, av, 1, 1, id, 1);
                m_tail = av;
                return;
            end
        end
        push(0, 0, 0, e, 1, 1, id, 0);
        m_tail = e;
    endfunction

    always @(negedge clk) begin : compare
        exp_t e;
        if (cmp_en) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("busy", busy, 1);
                chk("load_n", cnt_load_n, e.load_n);
                if (e.dir_care) chk("cnt_dir", cnt_dir, e.dir);
                if (e.d_care) chk("cnt_d", cnt_d, e.d);
                chk("done_valid", done_valid, e.dv);
                chk("ready0_busy", req0_ready, 0);
                chk("ready1_busy", req1_ready, 0);
                if (e.dv) begin
                    chk("done_id", done_id, e.id);
                    chk("done_err", done_err, e.err);
                    m_park = e.d;
                    done_cyc = cyc;
                    done_id_l = done_id;
                    done_err_l = done_err;
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_load_n", cnt_load_n, 0);
                chk("idle_cnt_d", cnt_d, m_park);
                chk("idle_done_valid", done_valid, 0);
                chk("ready0", req0_ready, req0_valid && (!req1_valid || !m_rr));
                chk("ready1", req1_ready, req1_valid && (!req0_valid || m_rr));
            end
        end
    end

    task automatic issue(bit v0, logic [3:0] s0, logic [3:0] e0, bit d0,
                         bit v1, logic [3:0] s1, logic [3:0] e1, bit d1,
                         int ak, logic [3:0] av, output int first);
        bit p0 = v0, p1 = v1;
        int g, guard = 0;
        first = -1;
        @(posedge clk); #1;
        req0_valid = v0; req0_start = s0; req0_stop = e0; req0_dir = d0;
        req1_valid = v1; req1_start = s1; req1_stop = e1; req1_dir = d1;
        while ((p0 || p1) && guard < 200) begin
            @(negedge clk);
            guard++;
            g = (p0 && req0_ready) ? 0 : (p1 && req1_ready) ? 1 : -1;
            if (g >= 0) begin
                if (first < 0) first = g;
                hs_cyc = cyc;
                @(posedge clk); #1;
                if (g == 0) begin
                    push_run(0, s0, e0, d0, ak, av);
                    req0_valid = 0; p0 = 0;
                end else begin
                    push_run(1, s1, e1, d1, ak, av);
                    req1_valid = 0; p1 = 0;
                end
                m_rr = (g == 0);
            end
        end
        chk("handshake_timeout", int'(p0 || p1), 0);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("idle_timeout", q.size(), 0);
    endtask

    initial begin
        int f;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_load_n", cnt_load_n, 0);
        chk("rst_cnt_d", cnt_d, 0);
        chk("rst_cnt_dir", cnt_dir, 1);
        chk("rst_done", done_valid, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_done_err", done_err, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        cmp_en = 1;

        issue(1, 0, 2, 1, 1, 9, 5, 0, -1, 0, f);
        chk("contention_first", f, 0);
        wait_idle();
        chk("contention_last_id", done_id_l, 1);
        chk("contention_last_err", done_err_l, 0);

        issue(1, 3, 7, 1, 0, 0, 0, 0, -1, 0, f);
        req1_valid = 1; req1_start = 1; req1_stop = 1; req1_dir = 1;
        @(posedge clk); #1;
        req1_valid = 0;
        wait_idle();
        chk("lat_3to7", done_cyc - hs_cyc, 8);
        chk("single_id", done_id_l, 0);
        chk("single_err", done_err_l, 0);
        @(negedge clk);
        chk("single_park", cnt_d, 7);

        issue(1, 4, 6, 1, 1, 12, 10, 0, -1, 0, f);
        chk("pair3_first", f, 1);
        wait_idle();

        issue(0, 0, 0, 0, 1, 5, 2, 1, -1, 0, f);
        wait_idle();
        chk("lat_illegal", done_cyc - hs_cyc, 1);
        chk("illegal_id", done_id_l, 1);
        chk("illegal_err", done_err_l, 1);
        @(negedge clk);
        chk("illegal_park", cnt_d, 6);

        inj = 1;
        issue(1, 3, 9, 1, 0, 0, 0, 0, 2, 6, f);
        wait_idle();
        inj = 0;
        chk("abort_err", done_err_l, 1);
        @(negedge clk);
        chk("abort_park", cnt_d, 6);

        issue(1, 0, 15, 1, 0, 0, 0, 0, -1, 0, f);
        wait_idle();
        chk("full_up_err", done_err_l, 0);
        chk("lat_full_up", done_cyc - hs_cyc, 19);
        issue(0, 0, 0, 0, 1, 15, 0, 0, -1, 0, f);
        wait_idle();
        chk("full_down_err", done_err_l, 0);
        issue(1, 8, 8, 1, 0, 0, 0, 0, -1, 0, f);
        wait_idle();
        chk("lat_8to8", done_cyc - hs_cyc, 4);
        chk("eq_err", done_err_l, 0);

        issue(1, 0, 15, 1, 0, 0, 0, 0, -1, 0, f);
        repeat (6) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        q.delete();
        m_park = 0; m_tail = 0; m_rr = 0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt_d", cnt_d, 0);
        chk("midrst_cnt_dir", cnt_dir, 1);
        chk("midrst_load_n", cnt_load_n, 0);
        chk("midrst_done", done_valid, 0);
        issue(1, 2, 4, 1, 0, 0, 0, 0, -1, 0, f);
        wait_idle();
        chk("post_rst_lat", done_cyc - hs_cyc, 6);
        chk("post_rst_err", done_err_l, 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
